// File: rtl/ieee32_pkg.sv
// ieee32_pkg: shared Q16.16 fixed-point type, unit constant and arithmetic helpers
// for the ieee32 synapse/plasticity model.
package ieee32_pkg;

  localparam int unsigned QW = 32;

  // Signed Q16.16 value
  typedef logic signed [QW-1:0] q16_t;

  // Fixed-point 1.0
  localparam q16_t ONE = 32'sh0001_0000;

  // Q16.16 multiply: full 64-bit signed product, bits [47:16] kept (truncating)
  function automatic q16_t qmul(input q16_t a, input q16_t b);
    return QW'((64'(a) * 64'(b)) >>> 16);
  endfunction

  // Signed add saturating to the 32-bit range
  function automatic q16_t sat_add(input q16_t a, input q16_t b);
    logic signed [QW:0] s;
    s = (QW+1)'(a) + (QW+1)'(b);
    if (s > 33'sh0_7FFF_FFFF) begin
      return 32'sh7FFF_FFFF;
    end else if (s < -33'sh0_8000_0000) begin
      return 32'sh8000_0000;
    end else begin
      return s[QW-1:0];
    end
  endfunction

endpackage

// File: rtl/ieee32_tick_gen.sv
// ieee32_tick_gen: divides the system clock into model ticks.
//   clk_0_1ps : system clock
//   reset     : async active-low reset
//   tick      : high for the one cycle in which count == DIV-1
//   count     : divider count, 0..DIV-1
//   clk       : phase probe, high while count < DIV/2 (never used as a clock)
module ieee32_tick_gen #(
  parameter int unsigned DIV = 25000,
  localparam int unsigned CW = $clog2(DIV)
) (
  input  logic          clk_0_1ps,
  input  logic          reset,
  output logic          tick,
  output logic [CW-1:0] count,
  output logic          clk
);

  logic [CW-1:0] count_nxt;

  // Wrap at DIV-1
  always_comb begin
    count_nxt = count + CW'(1);
    if (count == CW'(DIV - 1)) begin
      count_nxt = '0;
    end
  end

  // tick and clk are decoded from the next count so they line up with count
  always_ff @(posedge clk_0_1ps or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
      clk   <= 1'b1;
    end else begin
      count <= count_nxt;
      tick  <= (count_nxt == CW'(DIV - 1));
      clk   <= (count_nxt < CW'(DIV / 2));
    end
  end

endmodule

// File: rtl/ieee32_top.sv
// ieee32_top: one synapse with short-term facilitation/depression, synaptic current,
// membrane/inhibition filter and trace-based weight plasticity, updated once per tick.
//   clk_0_1ps, reset : system clock, async active-low reset
//   enable           : model registers update on ticks only while high
//   tp1, td4         : async pre/post spike levels
//   Isyn1..Yn        : Q16.16 model state
//   counter1         : divider count
//   remaining outputs: reserved, constant zero
module ieee32_top
  import ieee32_pkg::*;
#(
  parameter int unsigned DIV    = 25000,
  parameter q16_t        U0     = 32'sh0000_4000,
  parameter q16_t        W0     = 32'sh0000_8000,
  parameter q16_t        WMAX   = 32'sh0001_0000,
  parameter int unsigned TD_SH  = 4,
  parameter int unsigned TF_SH  = 5,
  parameter int unsigned TS_SH  = 3,
  parameter int unsigned TX_SH  = 4,
  parameter int unsigned RM_SH  = 2,
  parameter int unsigned ETA_SH = 4
) (
  input  logic        clk_0_1ps,
  input  logic        reset,
  input  logic        enable,
  input  logic        tp1,
  input  logic        td4,
  output q16_t        Isyn1,
  output q16_t        WWx,
  output q16_t        Ax,
  output q16_t        Dx,
  output q16_t        Prelx,
  output q16_t        RMtrx,
  output q16_t        Inhx,
  output q16_t        Xn,
  output q16_t        Yn,
  output logic [31:0] counter1,
  output logic [31:0] RMx, Cx, KKx, Sx, Mx, Vpostx1, Wpostx1,
  output logic [31:0] aq, bq, cq, dq, eq, fq, gq, hq, iq, Sq, S1q, S11q, k0q,
  output logic [31:0] ax, bx, cx, dx, ex, fx, gx,
  output logic [31:0] anq, bnq, cnq, dnq, enq, inq, jnq, knq, mnq, nnq, n1nq,
  output logic [31:0] pnq, qnq, unq, u1nq, vnq,
  output logic [31:0] Sk, ak, gk, Pxy, kk, qk, xk, SS, axx, bxx, cxx, Sy
);

  localparam int unsigned CW = $clog2(DIV);

  logic          tick;
  logic [CW-1:0] count;
  logic          clk_probe_unused;

  ieee32_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_0_1ps (clk_0_1ps),
    .reset     (reset),
    .tick      (tick),
    .count     (count),
    .clk       (clk_probe_unused)
  );

  assign counter1 = 32'(count);

  assign {RMx, Cx, KKx, Sx, Mx, Vpostx1, Wpostx1,
          aq, bq, cq, dq, eq, fq, gq, hq, iq, Sq, S1q, S11q, k0q,
          ax, bx, cx, dx, ex, fx, gx,
          anq, bnq, cnq, dnq, enq, inq, jnq, knq, mnq, nnq, n1nq,
          pnq, qnq, unq, u1nq, vnq,
          Sk, ak, gk, Pxy, kk, qk, xk, SS, axx, bxx, cxx, Sy} = '0;

  // Spike synchronizers run every cycle; edge history advances only on enabled ticks
  logic [1:0] tp1_sync, td4_sync;
  logic       tp1_hist, td4_hist;
  logic       upd, pre, post;

  assign upd  = tick & enable;
  assign pre  = upd & tp1_sync[1] & ~tp1_hist;
  assign post = upd & td4_sync[1] & ~td4_hist;

  always_ff @(posedge clk_0_1ps or negedge reset) begin
    if (!reset) begin
      tp1_sync <= '0;
      td4_sync <= '0;
      tp1_hist <= 1'b0;
      td4_hist <= 1'b0;
    end else begin
      tp1_sync <= {tp1_sync[0], tp1};
      td4_sync <= {td4_sync[0], td4};
      if (upd) begin
        tp1_hist <= tp1_sync[1];
        td4_hist <= td4_sync[1];
      end
    end
  end

  // Next model state, all from current (old) register values
  q16_t              dx_n, ax_n, prel_n, isyn_n, xn_n, yn_n, ww_n, inh_n, rm_n;
  logic signed [QW:0] w_sum;

  always_comb begin
    dx_n   = Dx + ((ONE - Dx) >>> TD_SH);
    ax_n   = Ax + ((U0 - Ax) >>> TF_SH);
    prel_n = qmul(Ax, Dx);
    isyn_n = Isyn1 - (Isyn1 >>> TS_SH);
    xn_n   = sat_add(Xn - (Xn >>> TX_SH), pre  ? ONE : 32'sd0);
    yn_n   = sat_add(Yn - (Yn >>> TX_SH), post ? ONE : 32'sd0);
    inh_n  = Yn >>> 2;
    rm_n   = RMtrx + ((Isyn1 - Inhx - RMtrx) >>> RM_SH);
    w_sum  = (QW+1)'(WWx);
    if (pre) begin
      dx_n   = dx_n - qmul(Prelx, Dx);
      ax_n   = ax_n + qmul(U0, ONE - Ax);
      isyn_n = isyn_n + qmul(WWx, Prelx);
      w_sum  = w_sum - (QW+1)'(Yn >>> ETA_SH);
    end
    if (post) begin
      w_sum = w_sum + (QW+1)'(Xn >>> ETA_SH);
    end
    // Clamp weight into [0, WMAX]
    if (w_sum < 33'sd0) begin
      ww_n = 32'sd0;
    end else if (w_sum > (QW+1)'(WMAX)) begin
      ww_n = WMAX;
    end else begin
      ww_n = w_sum[QW-1:0];
    end
  end

  // Model state register
  always_ff @(posedge clk_0_1ps or negedge reset) begin
    if (!reset) begin
      Dx    <= ONE;
      Ax    <= U0;
      Prelx <= U0;
      WWx   <= W0;
      Isyn1 <= 32'sd0;
      Xn    <= 32'sd0;
      Yn    <= 32'sd0;
      Inhx  <= 32'sd0;
      RMtrx <= 32'sd0;
    end else if (upd) begin
      Dx    <= dx_n;
      Ax    <= ax_n;
      Prelx <= prel_n;
      WWx   <= ww_n;
      Isyn1 <= isyn_n;
      Xn    <= xn_n;
      Yn    <= yn_n;
      Inhx  <= inh_n;
      RMtrx <= rm_n;
    end
  end

endmodule

// File: tb/tb_ieee32_top.sv
// tb_ieee32_top: directed checks of ieee32_top with DIV=4 against hand-computed values.
module tb_ieee32_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        tp1 = 1'b0;
  logic        td4 = 1'b0;
  logic [31:0] Isyn1, WWx, Ax, Dx, Prelx, RMtrx, Inhx, Xn, Yn, counter1;
  logic [31:0] rsv [0:54];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ieee32_top #(.DIV(4)) dut (
    .clk_0_1ps(clk), .reset(reset), .enable(enable), .tp1(tp1), .td4(td4),
    .Isyn1(Isyn1), .WWx(WWx), .Ax(Ax), .Dx(Dx), .Prelx(Prelx), .RMtrx(RMtrx),
    .Inhx(Inhx), .Xn(Xn), .Yn(Yn), .counter1(counter1),
    .RMx(rsv[0]), .Cx(rsv[1]), .KKx(rsv[2]), .Sx(rsv[3]), .Mx(rsv[4]),
    .Vpostx1(rsv[5]), .Wpostx1(rsv[6]),
    .aq(rsv[7]), .bq(rsv[8]), .cq(rsv[9]), .dq(rsv[10]), .eq(rsv[11]),
    .fq(rsv[12]), .gq(rsv[13]), .hq(rsv[14]), .iq(rsv[15]),
    .Sq(rsv[16]), .S1q(rsv[17]), .S11q(rsv[18]), .k0q(rsv[19]),
    .ax(rsv[20]), .bx(rsv[21]), .cx(rsv[22]), .dx(rsv[23]), .ex(rsv[24]),
    .fx(rsv[25]), .gx(rsv[26]),
    .anq(rsv[27]), .bnq(rsv[28]), .cnq(rsv[29]), .dnq(rsv[30]), .enq(rsv[31]),
    .inq(rsv[32]), .jnq(rsv[33]), .knq(rsv[34]), .mnq(rsv[35]), .nnq(rsv[36]),
    .n1nq(rsv[37]), .pnq(rsv[38]), .qnq(rsv[39]), .unq(rsv[40]), .u1nq(rsv[41]),
    .vnq(rsv[42]),
    .Sk(rsv[43]), .ak(rsv[44]), .gk(rsv[45]), .Pxy(rsv[46]), .kk(rsv[47]),
    .qk(rsv[48]), .xk(rsv[49]), .SS(rsv[50]), .axx(rsv[51]), .bxx(rsv[52]),
    .cxx(rsv[53]), .Sy(rsv[54])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Return #1 after the posedge on which the model tick is applied
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (counter1 == 32'd3) begin
        @(posedge clk);
        #1;
        found = 1'b1;
      end
    end
    check("tick_seen", 32'(found), 32'd1);
  endtask

  task automatic pulse(input bit p, input bit q);
    tp1 = p;
    td4 = q;
    wait_tick();
    tp1 = 1'b0;
    td4 = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_Dx"}, Dx, 32'h0001_0000);
    check({tag, "_Ax"}, Ax, 32'h0000_4000);
    check({tag, "_Prelx"}, Prelx, 32'h0000_4000);
    check({tag, "_WWx"}, WWx, 32'h0000_8000);
    check({tag, "_Isyn1"}, Isyn1, 32'h0);
    check({tag, "_Xn"}, Xn, 32'h0);
    check({tag, "_Yn"}, Yn, 32'h0);
    check({tag, "_Inhx"}, Inhx, 32'h0);
    check({tag, "_RMtrx"}, RMtrx, 32'h0);
  endtask

  task automatic check_reserved();
    logic [31:0] acc = '0;
    for (int i = 0; i < 55; i++) acc = acc | rsv[i];
    check("reserved_zero", acc, 32'h0);
  endtask

  // Assert reset between clock edges, release on a negedge
  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    check_reset_values("rst");
    check("rst_counter1", counter1, 32'd0);
    check_reserved();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle ticks leave the baseline unchanged
    repeat (10) wait_tick();
    check_reset_values("idle");
    check_reserved();

    // Single presynaptic spike (T1) and its follow-up tick (T2)
    pulse(1'b1, 1'b0);
    check("t1_Isyn1", Isyn1, 32'h0000_2000);
    check("t1_Dx", Dx, 32'h0000_C000);
    check("t1_Ax", Ax, 32'h0000_7000);
    check("t1_Xn", Xn, 32'h0001_0000);
    check("t1_Prelx", Prelx, 32'h0000_4000);
    wait_tick();
    check("t2_Prelx", Prelx, 32'h0000_5400);
    check("t2_Isyn1", Isyn1, 32'd7168);
    check("t2_Xn", Xn, 32'd61440);
    check("t2_RMtrx", RMtrx, 32'd2048);
    check("t2_Dx", Dx, 32'd50176);
    check("t2_Ax", Ax, 32'd28288);

    // Postsynaptic spike two ticks after pre: potentiation by decayed Xn
    pulse(1'b0, 1'b1);
    check("t3_WWx", WWx, 32'd36608);
    check("t3_Yn", Yn, 32'h0001_0000);
    check("t3_Xn", Xn, 32'd57600);
    check("t3_Dx", Dx, 32'd51136);
    check("t3_Ax", Ax, 32'd27916);
    check("t3_Prelx", Prelx, 32'd21658);
    check("t3_Isyn1", Isyn1, 32'd6272);
    check("t3_RMtrx", RMtrx, 32'd3328);
    wait_tick();
    check("t4_Inhx", Inhx, 32'd16384);
    check("t4_Yn", Yn, 32'd61440);

    // Pre after post: depression by Yn>>>4
    pulse(1'b1, 1'b0);
    check("t5_WWx", WWx, 32'd32768);

    // Repeated posts clamp the weight at WMAX
    repeat (20) begin
      pulse(1'b0, 1'b1);
      wait_tick();
    end
    check("clamp_max_WWx", WWx, 32'h0001_0000);

    // Repeated pres against a large Yn clamp the weight at 0
    repeat (12) begin
      pulse(1'b1, 1'b0);
      wait_tick();
    end
    check("clamp_min_WWx", WWx, 32'h0);

    // Asynchronous reset mid-activity, observed before the next clock edge
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_reset_values("async");
    check("async_counter1", counter1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    // First tick comes DIV cycles after release
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("rel_counter1", counter1, 32'(k));
    end
    check("rel_Xn", Xn, 32'h0);
    wait_tick();

    // Simultaneous pre and post use old Xn and old Yn
    pulse(1'b1, 1'b0);
    wait_tick();
    pulse(1'b1, 1'b1);
    check("both1_WWx", WWx, 32'd36608);
    check("both1_Yn", Yn, 32'h0001_0000);
    check("both1_Xn", Xn, 32'd123136);
    wait_tick();
    pulse(1'b1, 1'b1);
    check("both2_WWx", WWx, 32'd39983);
    check("both2_Xn", Xn, 32'd173761);
    check("both2_Yn", Yn, 32'd123136);

    // Disabled: spikes toggling, model holds, divider keeps running
    pulse_reset();
    enable = 1'b0;
    repeat (6) begin
      tp1 = ~tp1;
      td4 = ~td4;
      wait_tick();
    end
    check_reset_values("dis");
    check("dis_counter1_0", counter1, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("dis_counter1", counter1, 32'(k % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
